riscv_dmem_slave: RTL

Synthesizable data-memory slave for the RISC-V core, directly downstream of the processor's data-memory port. It consumes `mem_write`, `mem_read`, `data_addr` and `write_data`, and returns `read_data` with one cycle of latency. Stores are posted through a 2-entry write buffer that drains into a single-port word RAM. Reads forward from the buffer, so the core always sees its most recent store.

---
 rtl/riscv_dmem_slave_if.sv | 29 ++
 rtl/riscv_dmem_slave.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/riscv_dmem_slave_if.sv
// Data-memory bus between the core (master) and the memory slave.
//
// Handshake: the core raises mem_read and/or mem_write with data_addr,
// write_data and mem_wstrb. The slave takes the request at the rising edge
// where stall is low. While stall is high, the core holds every request
// signal unchanged. Load results come back one cycle after the accepting
// edge, qualified by read_valid. access_err flags the access accepted at the
// previous edge.
interface riscv_dmem_slave_if;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] data_addr;
  logic [31:0] write_data;
  logic [3:0]  mem_wstrb;
  logic [31:0] read_data;
  logic        read_valid;
  logic        stall;
  logic        access_err;

  modport master (
    output mem_write, mem_read, data_addr, write_data, mem_wstrb,
    input  read_data, read_valid, stall, access_err
  );

  modport slave (
    input  mem_write, mem_read, data_addr, write_data, mem_wstrb,
    output read_data, read_valid, stall, access_err
  );
endinterface

// File: rtl/riscv_dmem_slave.sv
// Data-memory slave: single-port word RAM behind a 2-entry posted write
// buffer. Loads return one cycle after acceptance. Buffered stores are
// forwarded byte-by-byte into the load result, so a load always sees the
// most recent store.
module riscv_dmem_slave #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic               clk,
  input logic               reset,
  riscv_dmem_slave_if.slave bus
);

  localparam int          IW         = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_W30  = 30'(DEPTH_WORDS);

  // Address decode. BASE_ADDR is word aligned, so the offset's low bits
  // match data_addr[1:0]. Addresses below BASE_ADDR wrap to a huge offset
  // and fail the range check.
  logic [31:0]   offset;
  logic [IW-1:0] idx;
  logic          legal;

  assign offset = bus.data_addr - BASE_ADDR;
  assign idx    = offset[IW+1:2];
  assign legal  = (offset[1:0] == 2'b00) && (offset[31:2] < DEPTH_W30);

  // Write buffer: slot 0 is the head (oldest entry).
  logic [1:0]    count;
  logic [IW-1:0] b_idx  [2];
  logic [31:0]   b_data [2];
  logic [3:0]    b_strb [2];

  // Request acceptance and RAM port arbitration. A pending mem_read claims
  // the port even when mem_write wins the request; that lets stores pile up
  // to two entries, at which point the forced drain breaks the tie.
  logic req, port_rd, wr_acc, rd_acc, push, drain;

  assign req     = bus.mem_read | bus.mem_write;
  assign port_rd = bus.mem_read & ~bus.stall;
  assign wr_acc  = bus.mem_write & ~bus.stall;
  assign rd_acc  = port_rd & ~bus.mem_write;
  assign push    = wr_acc & legal & (bus.mem_wstrb != 4'b0000);
  assign drain   = (count != 2'd0) & ~port_rd;

  assign bus.stall = (count == 2'd2) & req;

  // Buffer FIFO: push at the tail, drain from the head, both may coincide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 2'd0;
      for (int e = 0; e < 2; e++) begin
        b_idx[e]  <= '0;
        b_data[e] <= '0;
        b_strb[e] <= '0;
      end
    end else begin
      case ({push, drain})
        2'b11: begin
          if (count == 2'd1) begin
            b_idx[0]  <= idx;
            b_data[0] <= bus.write_data;
            b_strb[0] <= bus.mem_wstrb;
          end else begin
            b_idx[0]  <= b_idx[1];
            b_data[0] <= b_data[1];
            b_strb[0] <= b_strb[1];
            b_idx[1]  <= idx;
            b_data[1] <= bus.write_data;
            b_strb[1] <= bus.mem_wstrb;
          end
        end
        2'b01: begin
          b_idx[0]  <= b_idx[1];
          b_data[0] <= b_data[1];
          b_strb[0] <= b_strb[1];
          count     <= count - 2'd1;
        end
        2'b10: begin
          b_idx[count[0]]  <= idx;
          b_data[count[0]] <= bus.write_data;
          b_strb[count[0]] <= bus.mem_wstrb;
          count            <= count + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Single-port RAM: byte-masked drain of the head entry, or a word read.
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] ram_q;

  always_ff @(posedge clk) begin
    if (drain) begin
      for (int b = 0; b < 4; b++)
        if (b_strb[0][b]) mem[b_idx[0]][8*b +: 8] <= b_data[0][8*b +: 8];
    end else if (rd_acc) begin
      ram_q <= mem[idx];
    end
  end

  // Forwarding overlay from the live buffer, oldest first so newer bytes win.
  logic [31:0] fwd_data;
  logic [3:0]  fwd_mask;

  always_comb begin
    fwd_data = '0;
    fwd_mask = '0;
    for (int e = 0; e < 2; e++) begin
      if ((2'(e) < count) && (b_idx[e] == idx)) begin
        for (int b = 0; b < 4; b++) begin
          if (b_strb[e][b]) begin
            fwd_data[8*b +: 8] = b_data[e][8*b +: 8];
            fwd_mask[b]        = 1'b1;
          end
        end
      end
    end
  end

  // Response pipeline: capture read status and the overlay at acceptance.
  logic        rsp_valid, rsp_legal, rsp_err;
  logic [31:0] fwd_data_q;
  logic [3:0]  fwd_mask_q;
  logic [31:0] last_rd;
  logic [31:0] merged;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid  <= 1'b0;
      rsp_legal  <= 1'b0;
      rsp_err    <= 1'b0;
      fwd_data_q <= '0;
      fwd_mask_q <= '0;
    end else begin
      rsp_valid <= rd_acc;
      rsp_legal <= legal;
      rsp_err   <= (rd_acc | wr_acc) & ~legal;
      if (rd_acc) begin
        fwd_data_q <= fwd_data;
        fwd_mask_q <= fwd_mask;
      end
    end
  end

  // Merge RAM word with forwarded bytes; illegal reads return zero.
  always_comb begin
    merged = '0;
    for (int b = 0; b < 4; b++)
      merged[8*b +: 8] = fwd_mask_q[b] ? fwd_data_q[8*b +: 8] : ram_q[8*b +: 8];
    if (!rsp_legal) merged = '0;
  end

  // Hold the last returned value on read_data between responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         last_rd <= '0;
    else if (rsp_valid) last_rd <= merged;
  end

  assign bus.read_data  = rsp_valid ? merged : last_rd;
  assign bus.read_valid = rsp_valid;
  assign bus.access_err = rsp_err;

endmodule
